// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, operation mode,
// ACC shift/load select codes and the per-state control decode.
package muldiv_sequencer_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLR     = 3'd1;
  localparam logic [2:0] S_MUL_ADD = 3'd2;
  localparam logic [2:0] S_MUL_SHR = 3'd3;
  localparam logic [2:0] S_DIV_SHL = 3'd4;
  localparam logic [2:0] S_DIV_SUB = 3'd5;
  localparam logic [2:0] S_DIV_FIN = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [1:0] ACC_HOLD = 2'b00;
  localparam logic [1:0] ACC_SHR  = 2'b01;
  localparam logic [1:0] ACC_SHL  = 2'b10;
  localparam logic [1:0] ACC_LOAD = 2'b11;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       acc_high_reset_p;
    logic       acc_in_select;
    logic [1:0] acc_high_select;
    logic [1:0] acc_low_select;
    logic       op_mul;
    logic       op_div;
    logic       rd_en;
  } seq_ctrl_t;

  // Moore decode: every datapath control is a pure function of the state.
  function automatic seq_ctrl_t decode_state(input logic [2:0] s);
    seq_ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_CLR:     c.acc_high_reset_p = 1'b1;
      S_MUL_ADD: c.op_mul = 1'b1;
      S_MUL_SHR: begin
        c.acc_high_select = ACC_SHR;
        c.acc_low_select  = ACC_SHR;
      end
      S_DIV_SHL: begin
        c.acc_high_select = ACC_SHL;
        c.acc_low_select  = ACC_SHL;
      end
      S_DIV_SUB: c.op_div = 1'b1;
      S_DIV_FIN: c.acc_low_select = ACC_SHL;
      S_DONE: begin
        c.done  = 1'b1;
        c.rd_en = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit handshake and ALU/ACC control bundle of the multiply/divide sequencer.
interface muldiv_sequencer_if;
  logic       start;
  logic       cmd_mul;
  logic       cmd_div;
  logic       busy;
  logic       done;
  logic       cmd_err;
  logic       acc_high_reset_p;
  logic       acc_in_select;
  logic [1:0] acc_high_select;
  logic [1:0] acc_low_select;
  logic       op_mul;
  logic       op_div;
  logic       rd_en;

  modport master (
    output start, cmd_mul, cmd_div,
    input  busy, done, cmd_err
  );

  modport slave (
    input  start, cmd_mul, cmd_div,
    output busy, done, cmd_err,
    output acc_high_reset_p, acc_in_select, acc_high_select, acc_low_select,
    output op_mul, op_div, rd_en
  );

  modport datapath (
    input acc_high_reset_p, acc_in_select, acc_high_select, acc_low_select,
    input op_mul, op_div, rd_en
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Moore FSM sequencing block_alu_acc through shift-add multiply and restoring divide.
// Result is left in ACC as {high,low}; the control unit sees start/busy/done only.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int N_BITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic               clk,
  input  logic               reset_p,
  muldiv_sequencer_if.slave  sif
);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_iter;
  mode_e            r_mode;
  logic             r_cmd_err;
  logic             w_idle;
  logic             w_cmd_ok;
  logic             w_accept;
  logic             w_last;
  seq_ctrl_t        w_ctrl;

  assign w_idle   = (r_state == S_IDLE);
  assign w_cmd_ok = sif.cmd_mul ^ sif.cmd_div;
  assign w_accept = w_idle && sif.start && w_cmd_ok;
  assign w_last   = (r_iter == CNT_W'(N_BITS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_CLR;
      S_CLR:     w_next = (r_mode == MODE_MUL) ? S_MUL_ADD : S_DIV_SHL;
      S_MUL_ADD: w_next = S_MUL_SHR;
      S_MUL_SHR: w_next = w_last ? S_DONE : S_MUL_ADD;
      S_DIV_SHL: w_next = S_DIV_SUB;
      S_DIV_SUB: w_next = w_last ? S_DIV_FIN : S_DIV_SHL;
      S_DIV_FIN: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state   <= S_IDLE;
      r_iter    <= '0;
      r_mode    <= MODE_MUL;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      // An illegal command is rejected in IDLE and flagged for one cycle only.
      r_cmd_err <= w_idle && sif.start && !w_cmd_ok;
      if (w_accept)
        r_mode <= sif.cmd_div ? MODE_DIV : MODE_MUL;
      if (r_state == S_CLR)
        r_iter <= '0;
      else if ((r_state == S_MUL_SHR || r_state == S_DIV_SUB) && !w_last)
        r_iter <= r_iter + CNT_W'(1);
    end
  end

  assign w_ctrl = decode_state(r_state);

  assign sif.busy             = w_ctrl.busy;
  assign sif.done             = w_ctrl.done;
  assign sif.cmd_err          = r_cmd_err;
  assign sif.acc_high_reset_p = w_ctrl.acc_high_reset_p;
  assign sif.acc_in_select    = w_ctrl.acc_in_select;
  assign sif.acc_high_select  = w_ctrl.acc_high_select;
  assign sif.acc_low_select   = w_ctrl.acc_low_select;
  assign sif.op_mul           = w_ctrl.op_mul;
  assign sif.op_div           = w_ctrl.op_div;
  assign sif.rd_en            = w_ctrl.rd_en;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench: sequencer + behavioural ALU/ACC/BREG; results checked against plain arithmetic.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset_p = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_sequencer_if sif();

  muldiv_sequencer #(.N_BITS(4), .CNT_W(3)) dut (
    .clk(clk), .reset_p(reset_p), .sif(sif)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for block_alu_acc, BREG and the ACC low preload path.
  logic [3:0] acc_hi = '0, acc_lo = '0, breg = '0;
  logic       cf = 1'b0;
  logic       pre_en = 1'b0;
  logic [3:0] pre_lo = '0, pre_b = '0;
  logic [4:0] m_sum, m_diff;
  logic       m_cout;
  logic [1:0] m_hsel;
  logic [3:0] m_alu;

  always_comb begin
    m_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? breg : 4'h0)};
    m_diff = {1'b0, acc_hi} - {1'b0, breg};
    m_cout = ~m_diff[4];
    m_hsel = sif.acc_high_select;
    if (sif.op_mul && acc_lo[0]) m_hsel = 2'b11;
    if (sif.op_div && m_cout)    m_hsel = 2'b11;
    m_alu  = sif.op_div ? m_diff[3:0] : m_sum[3:0];
  end

  always @(posedge clk) begin
    if (pre_en) begin
      acc_lo <= pre_lo;
      breg   <= pre_b;
    end else begin
      if (sif.acc_high_reset_p) acc_hi <= '0;
      else case (m_hsel)
        2'b01: acc_hi <= {cf, acc_hi[3:1]};
        2'b10: acc_hi <= {acc_hi[2:0], acc_lo[3]};
        2'b11: acc_hi <= m_alu;
        default: ;
      endcase
      case (sif.acc_low_select)
        2'b01: acc_lo <= {acc_hi[0], acc_lo[3:1]};
        2'b10: acc_lo <= {acc_lo[2:0], cf};
        default: ;
      endcase
      if (sif.acc_high_reset_p) cf <= 1'b0;
      else if (sif.op_mul)      cf <= m_sum[4];
      else if (sif.op_div)      cf <= m_cout;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {sif.busy, sif.done, sif.cmd_err, sif.acc_high_reset_p, sif.acc_in_select,
            sif.acc_high_select, sif.acc_low_select, sif.op_mul, sif.op_div, sif.rd_en};
  endfunction

  // Runs one operation; inj > 0 pulses a stray start during that cycle.
  task automatic run_op(input bit div, input logic [3:0] a, input logic [3:0] b, input int inj,
                        output int lat, output int nbusy, output int nopm, output int ndone,
                        output int viol, output logic [7:0] res);
    lat = -1; nbusy = 0; nopm = 0; ndone = 0; viol = 0; res = '0;
    @(negedge clk);
    pre_en = 1'b1; pre_lo = a; pre_b = b;
    sif.start = 1'b1; sif.cmd_mul = !div; sif.cmd_div = div;
    @(negedge clk);
    pre_en = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      sif.start   = (k == inj);
      sif.cmd_mul = (k == inj);
      sif.cmd_div = 1'b0;
      if (sif.busy)   nbusy++;
      if (sif.op_mul) nopm++;
      if (sif.op_mul && sif.op_div) viol++;
      if (sif.acc_in_select) viol++;
      if (sif.done && !(sif.busy && sif.rd_en)) viol++;
      if (sif.done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          res = {acc_hi, acc_lo};
        end
      end
      if (lat > 0 && k >= lat + 3) break;
      @(negedge clk);
    end
    sif.start = 1'b0; sif.cmd_mul = 1'b0;
  endtask

  task automatic check_op(input string tag, input bit div, input logic [3:0] a,
                          input logic [3:0] b, input int inj, input bit full);
    int lat, nbusy, nopm, ndone, viol;
    logic [7:0] res, exp;
    int exp_lat;
    run_op(div, a, b, inj, lat, nbusy, nopm, ndone, viol, res);
    exp_lat = div ? 11 : 10;
    if (!div)        exp = 8'(int'(a) * int'(b));
    else if (b != 0) exp = {4'(a % b), 4'(a / b)};
    else             exp = {res[7:4], 4'hF};
    check({tag, "_res"}, res, exp);
    check({tag, "_lat"}, lat, exp_lat);
    if (full) begin
      check({tag, "_busy_cycles"}, nbusy, exp_lat);
      check({tag, "_done_pulses"}, ndone, 1);
      check({tag, "_invariants"}, viol, 0);
      if (!div) check({tag, "_op_mul_cycles"}, nopm, 4);
      check({tag, "_idle_after"}, sif.busy, 1'b0);
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.start = 1'b0; sif.cmd_mul = 1'b0; sif.cmd_div = 1'b0;
    #12;
    check("reset_outs", outs(), 12'h000);
    @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);
    check("idle_outs", outs(), 12'h000);

    check_op("mul_3x5", 1'b0, 4'd3, 4'd5, 0, 1'b1);
    check_op("mul_15x15", 1'b0, 4'd15, 4'd15, 0, 1'b1);
    check_op("div_13_3", 1'b1, 4'd13, 4'd3, 0, 1'b1);
    check_op("div_9_0", 1'b1, 4'd9, 4'd0, 0, 1'b1);

    // Illegal commands: both high, then both low.
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      sif.start = 1'b1; sif.cmd_mul = (m == 0); sif.cmd_div = (m == 0);
      @(negedge clk);
      sif.start = 1'b0; sif.cmd_mul = 1'b0; sif.cmd_div = 1'b0;
      check("cmd_err_pulse", sif.cmd_err, 1'b1);
      check("cmd_err_busy", sif.busy, 1'b0);
      @(negedge clk);
      check("cmd_err_once", {sif.cmd_err, sif.busy}, 2'b00);
    end

    // Stray start mid-multiply and during DONE must be dropped.
    check_op("mul_inj4", 1'b0, 4'd7, 4'd6, 4, 1'b1);
    check_op("mul_inj_done", 1'b0, 4'd11, 4'd9, 10, 1'b1);

    // Asynchronous reset in cycle 5 of a divide, between clock edges.
    @(negedge clk);
    pre_en = 1'b1; pre_lo = 4'd13; pre_b = 4'd3;
    sif.start = 1'b1; sif.cmd_div = 1'b1;
    @(negedge clk);
    pre_en = 1'b0; sif.start = 1'b0; sif.cmd_div = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", sif.busy, 1'b1);
    #2 reset_p = 1'b1;
    #1 check("async_reset_outs", outs(), 12'h000);
    @(negedge clk);
    reset_p = 1'b0;
    check_op("mul_after_reset", 1'b0, 4'd3, 4'd5, 0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      bit div;
      logic [3:0] a, b;
      div = 1'($urandom_range(0, 1));
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      check_op(div ? "rnd_div" : "rnd_mul", div, a, b, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
